// File: rtl/fb_combiner_if.sv
// Channel-product bus and feedback DAC outputs of fb_combiner.
// master drives products/controls and observes the DAC word; slave is the combiner.
interface fb_combiner_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IN_W  = 15,
  parameter int unsigned OUT_W = 13
);
  localparam int unsigned CNT_W = 16;

  logic                   store_strb;
  logic                   out_cond;
  logic [N_CH*IN_W-1:0]   ch_in;
  logic [N_CH-1:0]        ch_oflow;
  logic [N_CH-1:0]        ch_en_mask;
  logic [OUT_W-1:0]       offset;
  logic                   const_dac_en;
  logic [OUT_W-1:0]       const_dac;
  logic                   oflow_clr;
  logic [OUT_W-1:0]       fb_sgnl;
  logic                   fb_valid;
  logic                   oflow;
  logic                   oflow_sticky;
  logic [CNT_W-1:0]       sat_count;

  modport master (
    output store_strb, out_cond, ch_in, ch_oflow, ch_en_mask, offset,
           const_dac_en, const_dac, oflow_clr,
    input  fb_sgnl, fb_valid, oflow, oflow_sticky, sat_count
  );

  modport slave (
    input  store_strb, out_cond, ch_in, ch_oflow, ch_en_mask, offset,
           const_dac_en, const_dac, oflow_clr,
    output fb_sgnl, fb_valid, oflow, oflow_sticky, sat_count
  );
endinterface

// File: rtl/fb_combiner.sv
// Feedback combiner: masked sum of channel products plus offset, saturated to the DAC word.
// Optional slew limiter on computed updates when FB_SLEW_LIMIT_EN is defined.
module fb_combiner #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned IN_W     = 15,
  parameter int unsigned OUT_W    = 13,
  parameter int unsigned MAX_STEP = 64
) (
  input  logic         clk,
  input  logic         rst,
  fb_combiner_if.slave bus
);

  localparam int unsigned SUM_W  = IN_W + $clog2(N_CH + 1) + 1;
  localparam int unsigned SLOW_W = N_CH + 2 * OUT_W + 1;
  localparam int unsigned CNT_W  = 16;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2 ** (OUT_W - 1)));

  if (N_CH < 2 || N_CH > 8 || OUT_W > IN_W || MAX_STEP < 1 || MAX_STEP >= 2 ** OUT_W)
  begin : g_param_chk
    $error("fb_combiner: unsupported parameter set");
  end

  // Slow-domain controls: two-flop synchroniser on the packed control word
  logic [SLOW_W-1:0]       slow_c;
  logic [SLOW_W-1:0]       sync_a;
  logic [SLOW_W-1:0]       sync_b;
  logic [N_CH-1:0]         mask_s;
  logic signed [OUT_W-1:0] off_s;
  logic                    cen_s;
  logic signed [OUT_W-1:0] cdac_s;

  assign slow_c = {bus.ch_en_mask, bus.offset, bus.const_dac_en, bus.const_dac};
  assign {mask_s, off_s, cen_s, cdac_s} = sync_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= slow_c;
      sync_b <= sync_a;
    end
  end

  // Stage 1: masked channel capture; in-flight updates die while the window is closed
  logic signed [IN_W-1:0] s1_ch [N_CH];
  logic signed [IN_W-1:0] s1_off;
  logic                   s1_of;
  logic                   s1_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) s1_ch[i] <= '0;
      s1_off  <= '0;
      s1_of   <= 1'b0;
      s1_cond <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++)
        s1_ch[i] <= mask_s[i] ? bus.ch_in[i*IN_W +: IN_W] : '0;
      s1_off  <= IN_W'(off_s);
      s1_of   <= |(bus.ch_oflow & mask_s);
      s1_cond <= bus.out_cond & bus.store_strb;
    end
  end

  // Stage 2: full-width sum, wide enough that it never wraps
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] s2_sum;
  logic                    s2_of;
  logic                    s2_cond;

  always_comb begin
    sum_c = SUM_W'(s1_off);
    for (int i = 0; i < int'(N_CH); i++)
      sum_c = sum_c + SUM_W'(s1_ch[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sum  <= '0;
      s2_of   <= 1'b0;
      s2_cond <= 1'b0;
    end else begin
      s2_sum  <= sum_c;
      s2_of   <= s1_of;
      s2_cond <= s1_cond & bus.store_strb;
    end
  end

  // Stage 3: clip to the DAC range and flag the clip
  logic                    sat_hi_c;
  logic                    sat_lo_c;
  logic signed [OUT_W-1:0] clip_c;
  logic signed [OUT_W-1:0] s3_val;
  logic                    s3_sat;
  logic                    s3_of;
  logic                    s3_cond;

  always_comb begin
    sat_hi_c = (s2_sum > SAT_HI);
    sat_lo_c = (s2_sum < SAT_LO);
    clip_c   = OUT_W'(s2_sum);
    if (sat_hi_c)
      clip_c = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo_c)
      clip_c = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_val  <= '0;
      s3_sat  <= 1'b0;
      s3_of   <= 1'b0;
      s3_cond <= 1'b0;
    end else begin
      s3_val  <= clip_c;
      s3_sat  <= sat_hi_c | sat_lo_c;
      s3_of   <= s2_of;
      s3_cond <= s2_cond & bus.store_strb;
    end
  end

  logic signed [OUT_W-1:0] fb_q;
  logic signed [OUT_W-1:0] calc_c;

`ifdef FB_SLEW_LIMIT_EN
  localparam int unsigned DW = OUT_W + 2;
  localparam logic signed [DW-1:0] STEP = DW'(MAX_STEP);
  logic signed [DW-1:0] diff_c;

  // Clamp the computed word to within STEP of the word currently on the DAC
  always_comb begin
    diff_c = DW'(s3_val) - DW'(fb_q);
    calc_c = s3_val;
    if (diff_c > STEP)
      calc_c = OUT_W'(DW'(fb_q) + STEP);
    else if (diff_c < -STEP)
      calc_c = OUT_W'(DW'(fb_q) - STEP);
  end
`else
  assign calc_c = s3_val;
`endif

  // Output stage: gated update, overflow pulse, sticky flag and saturation counter
  logic                    upd_c;
  logic                    hit_c;
  logic                    ofl_c;
  logic signed [OUT_W-1:0] next_c;
  logic                    valid_q;
  logic                    oflow_q;
  logic                    sticky_q;
  logic [CNT_W-1:0]        cnt_q;

  assign upd_c  = bus.store_strb & s3_cond;
  assign hit_c  = upd_c & s3_sat & ~cen_s;
  assign ofl_c  = hit_c | (upd_c & s3_of);
  assign next_c = cen_s ? cdac_s : calc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q     <= '0;
      valid_q  <= 1'b0;
      oflow_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q <= upd_c;
      oflow_q <= ofl_c;
      if (!bus.store_strb)
        fb_q <= '0;
      else if (s3_cond)
        fb_q <= next_c;
      if (ofl_c)
        sticky_q <= 1'b1;
      else if (bus.oflow_clr)
        sticky_q <= 1'b0;
      if (bus.oflow_clr)
        cnt_q <= CNT_W'(hit_c);
      else if (hit_c && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fb_sgnl      = fb_q;
  assign bus.fb_valid     = valid_q;
  assign bus.oflow        = oflow_q;
  assign bus.oflow_sticky = sticky_q;
  assign bus.sat_count    = cnt_q;

endmodule

// File: tb/tb_fb_combiner.sv
// Scoreboard bench for fb_combiner: planned stimulus, cycle-indexed reference model, decoupled monitor.
module tb_fb_combiner;
  localparam int N_CH     = 4;
  localparam int IN_W     = 15;
  localparam int OUT_W    = 13;
  localparam int MAX_STEP = 64;
  localparam int CHW      = N_CH * IN_W;
  localparam int NCYC     = 2000;
`ifdef FB_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_combiner_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fb_combiner #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_STEP(MAX_STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Planned stimulus, one entry per post-reset edge
  bit       a_cond [NCYC];
  bit       a_store[NCYC];
  bit       a_clr  [NCYC];
  bit       a_cen  [NCYC];
  int       a_cdac [NCYC];
  int       a_off  [NCYC];
  logic [3:0] a_mask[NCYC];
  logic [3:0] a_chof[NCYC];
  int       a_ch   [NCYC][N_CH];
  bit       a_haslit[NCYC];
  int       a_lit  [NCYC];

  bit e_valid [NCYC];
  int e_fb    [NCYC];
  bit e_sticky[NCYC];
  int e_count [NCYC];

  typedef struct {
    int fb; bit oflow; bit sticky; int count; bit has_lit; int lit;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  int         p = 0;
  bit         cur_store = 1'b1;
  bit         cur_cen = 1'b0;
  int         cur_cdac = 0;
  int         cur_off = 0;
  logic [3:0] cur_mask = 4'hF;

  task automatic chk(string nm, int n, int got, int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, n, got, want);
    end
  endtask

  task automatic step(bit cond, int c0, int c1, int c2, int c3,
                      logic [3:0] chof, bit clr, bit haslit, int lit);
    if (p < NCYC) begin
      a_cond[p] = cond;     a_store[p] = cur_store; a_clr[p] = clr;
      a_cen[p]  = cur_cen;  a_cdac[p]  = cur_cdac;  a_off[p] = cur_off;
      a_mask[p] = cur_mask; a_chof[p]  = chof;
      a_ch[p][0] = c0; a_ch[p][1] = c1; a_ch[p][2] = c2; a_ch[p][3] = c3;
      a_haslit[p] = haslit; a_lit[p] = lit;
      p++;
    end
  endtask

  function automatic int rch();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 32767)) - 16384;
    return int'($urandom_range(0, 3000)) - 1500;
  endfunction

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(1'b0, rch(), rch(), rch(), rch(), 4'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic gen();
    // Plain sum
    cur_mask = 4'hF; cur_off = 10; idle(8);
    step(1'b1, 100, 200, -50, 25, 4'h0, 1'b0, !SLEW, 285); idle(4);
    // Saturation both ways, then clear
    step(1'b1, 4000, 4000, 4000, 4000, 4'h0, 1'b0, !SLEW, 4095); idle(4);
    step(1'b1, -4000, -4000, -4000, -4000, 4'h0, 1'b0, !SLEW, -4096); idle(4);
    step(1'b0, 0, 0, 0, 0, 4'h0, 1'b1, 1'b0, 0); idle(3);
    // Channel mask, masked-off overflow ignored
    cur_mask = 4'b0101; cur_off = 0; idle(8);
    step(1'b1, 1000, 7, -300, 9, 4'h0, 1'b0, !SLEW, 700);
    step(1'b1, 1000, 7, -300, 9, 4'b0010, 1'b0, !SLEW, 700); idle(4);
    // Constant override
    cur_cen = 1'b1; cur_cdac = -1234; idle(6);
    step(1'b1, rch(), rch(), rch(), rch(), 4'h0, 1'b0, 1'b1, -1234); idle(4);
    cur_cen = 1'b0; cur_mask = 4'hF; idle(8);
    // Window drop in a full-rate stream
    for (int i = 0; i < 6; i++) step(1'b1, 10, 0, 0, 0, 4'h0, 1'b0, 1'b0, 0);
    cur_store = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b1, 10, 0, 0, 0, 4'h0, 1'b0, 1'b0, 0);
    cur_store = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 20, 0, 0, 0, 4'h0, 1'b0, 1'b0, 0);
    // Slew ramp from a forced zero
    cur_store = 1'b0; idle(1); cur_store = 1'b1; idle(3);
    step(1'b1, 1000, 0, 0, 0, 4'h0, 1'b0, 1'b1, SLEW ? MAX_STEP : 1000);
    for (int i = 0; i < 19; i++) step(1'b1, 1000, 0, 0, 0, 4'h0, 1'b0, 1'b0, 0);
    // Random traffic
    while (p < NCYC - 10) begin
      if ((p % 40) == 0) begin
        cur_mask = 4'($urandom());
        cur_off  = int'($urandom_range(0, 8191)) - 4096;
        cur_cen  = ($urandom_range(0, 5) == 0);
        cur_cdac = int'($urandom_range(0, 8191)) - 4096;
      end
      if (cur_store) cur_store = ($urandom_range(0, 24) != 0);
      else           cur_store = ($urandom_range(0, 2) == 0);
      step(1'($urandom_range(0, 1)), rch(), rch(), rch(), rch(),
           ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'h0,
           ($urandom_range(0, 29) == 0), 1'b0, 0);
    end
    cur_store = 1'b1;
    while (p < NCYC) idle(1);
  endtask

  // Reference model: an update at edge n carries data sampled at n-3 if the window
  // stayed open throughout; synchronised controls lag their inputs by two edges.
  task automatic run_model();
    int fb, cnt, sum, satv, d, m, c, off;
    bit stk, upd, ofl, hit, sat;
    logic [3:0] mk;
    fb = 0; cnt = 0; stk = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      ofl = 1'b0; hit = 1'b0;
      upd = (n >= 3) && a_cond[n-3] && a_store[n-3] && a_store[n-2] && a_store[n-1] && a_store[n];
      if (!a_store[n]) fb = 0;
      else if (upd) begin
        d = n - 3; m = d - 2; c = n - 2;
        mk  = (m >= 0) ? a_mask[m] : 4'h0;
        off = (m >= 0) ? a_off[m] : 0;
        sum = off;
        for (int i = 0; i < N_CH; i++) if (mk[i]) sum += a_ch[d][i];
        sat  = (sum > 4095) || (sum < -4096);
        satv = (sum > 4095) ? 4095 : (sum < -4096) ? -4096 : sum;
        if (a_cen[c]) fb = a_cdac[c];
        else begin
          if (SLEW && satv > fb + MAX_STEP) satv = fb + MAX_STEP;
          else if (SLEW && satv < fb - MAX_STEP) satv = fb - MAX_STEP;
          fb = satv;
        end
        hit = sat && !a_cen[c];
        ofl = hit || ((a_chof[d] & mk) != 4'h0);
      end
      if (ofl) stk = 1'b1;
      else if (a_clr[n]) stk = 1'b0;
      if (a_clr[n]) cnt = hit ? 1 : 0;
      else if (hit && cnt < 65535) cnt++;
      e_valid[n] = upd; e_fb[n] = fb; e_sticky[n] = stk; e_count[n] = cnt;
      if (upd) sbq.push_back('{fb, ofl, stk, cnt, a_haslit[n-3], a_lit[n-3]});
    end
  endtask

  task automatic drive_rand();
    bus.out_cond     = 1'($urandom());
    bus.store_strb   = 1'($urandom());
    bus.ch_in        = CHW'({$urandom(), $urandom()});
    bus.ch_oflow     = 4'($urandom());
    bus.ch_en_mask   = 4'($urandom());
    bus.offset       = OUT_W'($urandom());
    bus.const_dac_en = 1'($urandom());
    bus.const_dac    = OUT_W'($urandom());
    bus.oflow_clr    = 1'($urandom());
  endtask

  task automatic drive(int n);
    bus.out_cond     = a_cond[n];
    bus.store_strb   = a_store[n];
    for (int i = 0; i < N_CH; i++) bus.ch_in[i*IN_W +: IN_W] = IN_W'(a_ch[n][i]);
    bus.ch_oflow     = a_chof[n];
    bus.ch_en_mask   = a_mask[n];
    bus.offset       = OUT_W'(a_off[n]);
    bus.const_dac_en = a_cen[n];
    bus.const_dac    = OUT_W'(a_cdac[n]);
    bus.oflow_clr    = a_clr[n];
  endtask

  // Stimulus
  initial begin
    gen();
    run_model();
    rst = 1'b1;
    drive_rand();
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      drive(n);
      @(negedge clk);
    end
  end

  // Monitor
  initial begin
    exp_t e;
    int   fbg;
    for (int r = -2; r < 0; r++) begin
      @(posedge clk); #1;
      chk("rst_fb_sgnl", r, int'($signed(bus.fb_sgnl)), 0);
      chk("rst_fb_valid", r, int'(bus.fb_valid), 0);
      chk("rst_oflow", r, int'(bus.oflow), 0);
      chk("rst_sticky", r, int'(bus.oflow_sticky), 0);
      chk("rst_sat_count", r, int'(bus.sat_count), 0);
    end
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk); #1;
      fbg = int'($signed(bus.fb_sgnl));
      chk("fb_valid", n, int'(bus.fb_valid), int'(e_valid[n]));
      if (bus.fb_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_update cycle=%0d got fb_sgnl=%0d want no update", n, fbg);
        end else begin
          e = sbq.pop_front();
          chk("upd_fb_sgnl", n, fbg, e.fb);
          chk("upd_oflow", n, int'(bus.oflow), int'(e.oflow));
          if (e.has_lit) chk("directed_fb_sgnl", n, fbg, e.lit);
        end
      end else begin
        chk("idle_fb_sgnl", n, fbg, e_fb[n]);
        chk("idle_oflow", n, int'(bus.oflow), 0);
      end
      chk("oflow_sticky", n, int'(bus.oflow_sticky), int'(e_sticky[n]));
      chk("sat_count", n, int'(bus.sat_count), e_count[n]);
    end
    chk("scoreboard_drained", NCYC, sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
